// File: rtl/uart_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_sched_if
// Description : Source-side byte streams and the UART transmitter handshake
//               that the frame scheduler sits between.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  // Environment side: telemetry sources plus the UART transmitter
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_sched
// Description : Round-robin scheduler sharing one 8N1 UART transmitter among
//               NREQ packet sources. Each packet goes out as
//               SYNC, ID, payload..., XOR checksum(ID and payload).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_sched #(
  parameter int         NREQ      = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_frame_sched_if.slave  bus,
  output logic [2:0]         grant_id,
  output logic               frame_busy,
  output logic               frame_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC      = 3'd1,
    PAY_FETCH = 3'd2,
    TX_START  = 3'd3,
    TX_HOLD   = 3'd4,
    TX_WAIT   = 3'd5
  } state_t;

  // Which frame byte the byte-send sequence is currently carrying
  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_ID   = 2'd1,
    PH_PAY  = 2'd2,
    PH_CSUM = 2'd3
  } phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [2:0]  grant_n;
  logic [7:0]  tx_data, tx_data_n;
  logic [7:0]  checksum, checksum_n;
  logic        last_byte, last_byte_n;
  logic [2:0]  rr_ptr, rr_ptr_n;
  logic        frame_busy_n;
  logic        frame_done_n;
  logic        tx_start;
  logic [NREQ-1:0] ready;

  // Zero-padded views so a 3-bit source index always selects in range
  logic [7:0]  valid8;
  logic [7:0]  last8;
  logic [63:0] data64;
  logic [7:0]  grant_byte;
  logic        found;
  logic [2:0]  pick;
  logic [3:0]  scan_idx;

  assign valid8     = 8'(bus.req_valid);
  assign last8      = 8'(bus.req_last);
  assign data64     = 64'(bus.req_data);
  assign grant_byte = data64[{grant_id, 3'b000} +: 8];

  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = tx_start;
  assign bus.req_ready = ready;

  // Round-robin search: first valid source at or after rr_ptr, modulo NREQ
  always_comb begin
    found    = 1'b0;
    pick     = 3'd0;
    scan_idx = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(i);
      if (scan_idx >= 4'(NREQ)) scan_idx = scan_idx - 4'(NREQ);
      if (!found && valid8[scan_idx[2:0]]) begin
        found = 1'b1;
        pick  = scan_idx[2:0];
      end
    end
  end

  // Next-state and output decode; ID and checksum bytes are loaded on the
  // TX_WAIT exit so they launch one cycle after tx_busy falls
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    grant_n      = grant_id;
    tx_data_n    = tx_data;
    checksum_n   = checksum;
    last_byte_n  = last_byte;
    rr_ptr_n     = rr_ptr;
    frame_busy_n = frame_busy;
    frame_done_n = 1'b0;
    tx_start     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i] = (state == PAY_FETCH) && (grant_id == 3'(i));
    end
    case (state)
      IDLE: begin
        if (found) begin
          grant_n      = pick;
          frame_busy_n = 1'b1;
          checksum_n   = 8'h00;
          state_n      = SYNC;
        end
      end
      SYNC: begin
        tx_data_n = SYNC_BYTE;
        phase_n   = PH_SYNC;
        state_n   = TX_START;
      end
      PAY_FETCH: begin
        if (valid8[grant_id]) begin
          tx_data_n   = grant_byte;
          checksum_n  = checksum ^ grant_byte;
          last_byte_n = last8[grant_id];
          phase_n     = PH_PAY;
          state_n     = TX_START;
        end
      end
      TX_START: begin
        tx_start = 1'b1;
        state_n  = TX_HOLD;
      end
      TX_HOLD: begin
        state_n = TX_WAIT;
      end
      TX_WAIT: begin
        if (!bus.tx_busy) begin
          case (phase)
            PH_SYNC: begin
              tx_data_n  = {5'b0, grant_id};
              checksum_n = checksum ^ {5'b0, grant_id};
              phase_n    = PH_ID;
              state_n    = TX_START;
            end
            PH_ID: begin
              state_n = PAY_FETCH;
            end
            PH_PAY: begin
              if (last_byte) begin
                tx_data_n = checksum;
                phase_n   = PH_CSUM;
                state_n   = TX_START;
              end else begin
                state_n = PAY_FETCH;
              end
            end
            default: begin
              frame_done_n = 1'b1;
              frame_busy_n = 1'b0;
              rr_ptr_n     = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
              state_n      = IDLE;
            end
          endcase
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= PH_SYNC;
      grant_id   <= 3'd0;
      tx_data    <= 8'h00;
      checksum   <= 8'h00;
      last_byte  <= 1'b0;
      rr_ptr     <= 3'd0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      grant_id   <= grant_n;
      tx_data    <= tx_data_n;
      checksum   <= checksum_n;
      last_byte  <= last_byte_n;
      rr_ptr     <= rr_ptr_n;
      frame_busy <= frame_busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_sched
// Description : Directed, table-driven bench for uart_frame_sched with a
//               UART busy model and byte/handshake monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_sched;
  localparam int NREQ  = 4;
  localparam int GUARD = 3000;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] grant_id;
  logic frame_busy, frame_done;

  always #5 clk = ~clk;

  uart_frame_sched_if #(.NREQ(NREQ)) bus ();

  uart_frame_sched #(.NREQ(NREQ), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;
  int busy_len = 3;

  // Monitor state
  logic [7:0] tx_q[$];
  int gap_q[$];
  int hs_cnt[NREQ];
  int cyc = 0, fall_cyc = 0, done_cnt = 0;
  int viol_busy = 0, viol_width = 0, viol_data = 0, viol_ready = 0;
  logic prev_busy = 1'b0, prev_start = 1'b0, in_win = 1'b0, saw_busy = 1'b0;
  logic [7:0] hold_data = 8'h00;

  typedef struct {
    int          src;
    int          len;
    logic [31:0] pay;
    logic [7:0]  csum;
    int          blen;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bytes(input string name, input int base, input logic [7:0] exp[$]);
    check($sformatf("%s length", name), tx_q.size() - base, exp.size());
    foreach (exp[k]) begin
      if (base + k < tx_q.size()) check($sformatf("%s byte%0d", name, k), tx_q[base+k], exp[k]);
    end
  endtask

  // Offer one byte on source s; returns once accepted, or early on reset
  task automatic send_byte(input int s, input logic [7:0] d, input logic l, output logic ok);
    int guard = 0;
    ok = 1'b1;
    bus.req_data[s*8 +: 8] = d;
    bus.req_last[s] = l;
    bus.req_valid[s] = 1'b1;
    while (!bus.req_ready[s]) begin
      if (!rst_n) begin ok = 1'b0; break; end
      if (guard >= GUARD) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL handshake src%0d: no ready after %0d cycles, ready required", s, guard);
        break;
      end
      @(posedge clk); #1; guard++;
    end
    if (ok) begin @(posedge clk); #1; end
    bus.req_valid[s] = 1'b0;
  endtask

  task automatic send_pkt(input int s, input int len, input logic [31:0] pay);
    logic ok;
    for (int b = 0; b < len; b++) begin
      send_byte(s, pay[8*b +: 8], b == len - 1, ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int g = 0;
    while (done_cnt < target && g < budget) begin @(posedge clk); #1; g++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s: frame_done count %0d, required %0d", name, done_cnt, target);
    end
  endtask

  // UART model: busy rises the cycle after tx_start and lasts busy_len cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        @(posedge clk); #1 bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Output monitor sampled on the falling edge
  initial begin
    foreach (hs_cnt[i]) hs_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) in_win = 1'b0;
      if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
      if (bus.tx_start) begin
        tx_q.push_back(bus.tx_data);
        gap_q.push_back(cyc - fall_cyc);
        if (bus.tx_busy) viol_busy++;
        if (prev_start) viol_width++;
        hold_data = bus.tx_data; in_win = 1'b1; saw_busy = 1'b0;
      end else if (in_win) begin
        if (bus.tx_data !== hold_data) viol_data++;
        if (bus.tx_busy) saw_busy = 1'b1;
        else if (saw_busy) in_win = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) if (bus.req_valid[i] && bus.req_ready[i]) hs_cnt[i]++;
      if ($countones(bus.req_ready) > 1) viol_ready++;
      if (frame_done) done_cnt++;
      prev_busy = bus.tx_busy;
      prev_start = bus.tx_start;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    logic [7:0] e[$];
    logic [7:0] eb;
    int base, d0, h0, h3, nb, g;
    logic ok;

    vt[0] = '{1, 2, 32'h0000_2211, 8'h32, 3};
    vt[1] = '{0, 1, 32'h0000_0040, 8'h40, 1};
    vt[2] = '{2, 1, 32'h0000_0042, 8'h40, 2};
    vt[3] = '{2, 3, 32'h003C_A55A, 8'hC1, 5};
    vt[4] = '{0, 1, 32'h0000_0000, 8'h00, 1};
    vt[5] = '{3, 4, 32'hF00F_00FF, 8'h03, 2};

    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", bus.req_ready, 0);
    check("reset tx_start", bus.tx_start, 0);
    check("reset tx_data", bus.tx_data, 8'h00);
    check("reset grant_id", grant_id, 0);
    check("reset frame_busy", frame_busy, 0);
    check("reset frame_done", frame_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Grant latency: busy next edge, SYNC launch one cycle later
    busy_len = 2; base = tx_q.size(); d0 = done_cnt;
    fork
      send_byte(2, 8'h99, 1'b1, ok);
      begin
        @(negedge clk);
        check("lat idle frame_busy", frame_busy, 0);
        @(negedge clk);
        check("lat grant frame_busy", frame_busy, 1);
        check("lat grant tx_start", bus.tx_start, 0);
        check("lat grant_id", grant_id, 2);
        @(negedge clk);
        check("lat sync tx_start", bus.tx_start, 1);
        check("lat sync tx_data", bus.tx_data, 8'hA5);
      end
    join
    wait_done(d0 + 1, GUARD, "latency frame");
    e = {8'hA5, 8'h02, 8'h99, 8'h9B};
    check_bytes("latency frame", base, e);

    // Table of single-source packets
    for (int n = 0; n < 6; n++) begin
      busy_len = vt[n].blen; base = tx_q.size(); d0 = done_cnt; h0 = hs_cnt[vt[n].src];
      send_pkt(vt[n].src, vt[n].len, vt[n].pay);
      wait_done(d0 + 1, GUARD, $sformatf("vec%0d done", n));
      repeat (3) @(posedge clk); #1;
      check($sformatf("vec%0d frame_done pulses", n), done_cnt - d0, 1);
      check($sformatf("vec%0d handshakes", n), hs_cnt[vt[n].src] - h0, vt[n].len);
      check($sformatf("vec%0d frame_busy after", n), frame_busy, 0);
      check($sformatf("vec%0d length", n), tx_q.size() - base, vt[n].len + 3);
      for (int k = 0; k < vt[n].len + 3; k++) begin
        if (k == 0) eb = 8'hA5;
        else if (k == 1) eb = 8'(vt[n].src);
        else if (k < vt[n].len + 2) eb = vt[n].pay[8*(k-2) +: 8];
        else eb = vt[n].csum;
        if (base + k < tx_q.size()) begin
          check($sformatf("vec%0d byte%0d", n, k), tx_q[base+k], eb);
          if (k >= 1)
            check($sformatf("vec%0d gap%0d", n, k), gap_q[base+k],
                  (k >= 2 && k < vt[n].len + 2) ? 2 : 1);
        end
      end
    end

    // Round robin: sources 0 and 2 continuously valid, pointer at 0
    busy_len = 2; base = tx_q.size(); d0 = done_cnt;
    fork
      begin send_pkt(0, 1, 32'h40); send_pkt(0, 1, 32'h40); end
      begin send_pkt(2, 1, 32'h42); send_pkt(2, 1, 32'h42); end
    join
    wait_done(d0 + 4, GUARD, "round robin done");
    e = {8'hA5, 8'h00, 8'h40, 8'h40, 8'hA5, 8'h02, 8'h42, 8'h40,
         8'hA5, 8'h00, 8'h40, 8'h40, 8'hA5, 8'h02, 8'h42, 8'h40};
    check_bytes("round robin", base, e);

    // Wrap-around: pointer at NREQ-1, sources 3 and 0 valid
    busy_len = 1; base = tx_q.size(); d0 = done_cnt;
    fork
      send_pkt(3, 1, 32'h0C);
      send_pkt(0, 1, 32'h0D);
    join
    wait_done(d0 + 2, GUARD, "wrap done");
    e = {8'hA5, 8'h03, 8'h0C, 8'h0F, 8'hA5, 8'h00, 8'h0D, 8'h0D};
    check_bytes("wrap", base, e);

    // Payload stall on source 3 while source 0 waits
    busy_len = 3; base = tx_q.size(); d0 = done_cnt; h0 = hs_cnt[0]; h3 = hs_cnt[3];
    fork
      begin
        send_byte(3, 8'h10, 1'b0, ok);
        repeat (10) @(posedge clk); #1;
        nb = tx_q.size() - base;
        check("stall bytes before gap", nb, 3);
        check("stall grant_id", grant_id, 3);
        check("stall frame_busy", frame_busy, 1);
        repeat (38) @(posedge clk); #1;
        check("stall no tx_start in gap", tx_q.size() - base, nb);
        check("stall src0 not served", hs_cnt[0] - h0, 0);
        check("stall grant held", grant_id, 3);
        send_byte(3, 8'h20, 1'b0, ok);
        send_byte(3, 8'h44, 1'b1, ok);
      end
      begin
        repeat (5) @(posedge clk); #1;
        send_byte(0, 8'h77, 1'b1, ok);
      end
    join
    wait_done(d0 + 2, GUARD, "stall done");
    check("stall src3 handshakes", hs_cnt[3] - h3, 3);
    e = {8'hA5, 8'h03, 8'h10, 8'h20, 8'h44, 8'h77, 8'hA5, 8'h00, 8'h77, 8'h77};
    check_bytes("stall", base, e);

    // Slow transmitter pacing
    busy_len = 1000; base = tx_q.size(); d0 = done_cnt;
    send_pkt(2, 2, 32'h0000_7E81);
    wait_done(d0 + 1, 8000, "pacing done");
    e = {8'hA5, 8'h02, 8'h81, 8'h7E, 8'hFD};
    check_bytes("pacing", base, e);
    check("tx_start while busy", viol_busy, 0);
    check("tx_start wider than 1", viol_width, 0);
    check("tx_data unstable", viol_data, 0);
    check("req_ready not onehot0", viol_ready, 0);

    // Asynchronous reset during payload byte 2 of 4
    busy_len = 20; base = tx_q.size(); h0 = hs_cnt[1];
    fork
      send_pkt(1, 4, 32'h0403_0201);
      begin
        g = 0;
        while (hs_cnt[1] - h0 < 2 && g < GUARD) begin @(posedge clk); #1; g++; end
        check("reset test reached byte2", hs_cnt[1] - h0, 2);
        repeat (3) @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midreset req_ready", bus.req_ready, 0);
        check("midreset tx_start", bus.tx_start, 0);
        check("midreset tx_data", bus.tx_data, 8'h00);
        check("midreset grant_id", grant_id, 0);
        check("midreset frame_busy", frame_busy, 0);
        check("midreset frame_done", frame_done, 0);
        repeat (25) @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    e = {8'hA5, 8'h01, 8'h01, 8'h02};
    check_bytes("aborted frame", base, e);
    bus.req_valid = '0;
    repeat (2) @(posedge clk); #1;
    busy_len = 2; base = tx_q.size(); d0 = done_cnt;
    send_pkt(2, 1, 32'h5A);
    wait_done(d0 + 1, GUARD, "post-reset done");
    e = {8'hA5, 8'h02, 8'h5A, 8'h58};
    check_bytes("post-reset frame", base, e);
    check("final tx_start while busy", viol_busy, 0);
    check("final req_ready onehot0", viol_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
